mc_main_controller: RTL

//  Main control FSM for the multicycle MIPS datapath.

---
 rtl/mc_main_controller.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mc_main_controller.sv
// Main control FSM for the multicycle MIPS datapath: Moore control outputs, fetch counter
// and illegal-opcode flag. Define MC_BNE_EN to add the BNE execute state.
module mc_main_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    output logic             iord,
    output logic             ir_write,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JEX    = 4'd11,
        S_BNEEX  = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    typedef struct packed {
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
    } ctrl_t;

    // Control word asserted while the FSM sits in state s.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: c.iord = 1'b1;
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_RTEX: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_RTWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BEQEX: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            S_JEX: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
`ifdef MC_BNE_EN
            S_BNEEX: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_src    = 2'b01;
                c.branch_ne = 1'b1;
            end
`endif
            default: ;
        endcase
        return c;
    endfunction

    state_t           state_reg;
    state_t           state_next;
    ctrl_t            ctrl_reg;
    ctrl_t            ctrl_out;
    logic [CNT_W-1:0] instr_count_reg;

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTEX;
                    OP_BEQ:       state_next = S_BEQEX;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JEX;
`ifdef MC_BNE_EN
                    OP_BNE:       state_next = S_BNEEX;
`endif
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = S_MEMWB;
            S_RTEX:   state_next = S_RTWB;
            S_ADDIEX: state_next = S_ADDIWB;
            default:  state_next = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state; its reset value is the FETCH
    // word so the first cycle after release already loads IR and PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= S_FETCH;
            ctrl_reg        <= ctrl_for(S_FETCH);
            instr_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= ctrl_for(state_next);
            if (state_reg == S_FETCH) begin
                instr_count_reg <= instr_count_reg + CNT_W'(1);
            end
        end
    end

    // Holding reset low must silence every enable and select immediately.
    assign ctrl_out = reset ? ctrl_reg : '0;

    assign iord        = ctrl_out.iord;
    assign ir_write    = ctrl_out.ir_write;
    assign mem_write   = ctrl_out.mem_write;
    assign reg_write   = ctrl_out.reg_write;
    assign reg_dst     = ctrl_out.reg_dst;
    assign mem_to_reg  = ctrl_out.mem_to_reg;
    assign alu_src_a   = ctrl_out.alu_src_a;
    assign alu_src_b   = ctrl_out.alu_src_b;
    assign alu_op      = ctrl_out.alu_op;
    assign pc_src      = ctrl_out.pc_src;
    assign pc_en       = ctrl_out.pc_write
                       | (ctrl_out.branch & zero)
                       | (ctrl_out.branch_ne & ~zero);
    assign illegal_op  = reset && (state_reg == S_DECODE) && (state_next == S_FETCH);
    assign state       = state_reg;
    assign instr_count = instr_count_reg;

endmodule
